pipelined_subtractor: RTL and testbench

- 16-bit signed two-stage pipelined subtractor: diff = n1 - n2, full-precision 17-bit sign-extended result plus a 16-bit signed overflow flag.
- Datapath is split into two 8-bit halves: the low half and its borrow are computed in stage 1, the high half in stage 2.
- Wrapped in a valid/ready handshake with backpressure, so it drops into streaming arithmetic paths next to the adder datapath.
- Throughput is one operation per clock when the downstream is ready.

---
 rtl/pipelined_subtractor_if.sv | 25 ++
 rtl/pipelined_subtractor.sv | 75 +++++++
 tb/tb_pipelined_subtractor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_if.sv
// Valid/ready stream bundle for the pipelined subtractor: operand pair in, difference plus overflow out.
interface pipelined_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;
  logic             ovf;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, n1, n2, out_ready,
    input  in_ready, out_valid, diff, ovf
  );

  // Subtractor side.
  modport slave (
    input  in_valid, n1, n2, out_ready,
    output in_ready, out_valid, diff, ovf
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Two-stage signed subtractor: the low half and its borrow are computed in stage 1,
// the sign-extended high half in stage 2, behind a valid/ready handshake with backpressure.
module pipelined_subtractor #(
  parameter int WIDTH = 16,
  localparam int HALF = WIDTH / 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_subtractor_if.slave bus
);

  logic            r_s1_valid;
  logic [HALF:0]   r_s1_lo;
  logic [HALF-1:0] r_n1_hi;
  logic [HALF-1:0] r_n2_hi;
  logic            r_out_valid;
  logic [WIDTH:0]  r_diff;
  logic            r_ovf;

  logic            w_s2_free;
  logic            w_s1_adv;
  logic            w_in_ready;
  logic            w_in_xfer;
  logic [HALF:0]   w_lo;
  logic [HALF:0]   w_hi;

  // Stage 2 can take new data if it is empty or its result leaves on this edge.
  assign w_s2_free  = !r_out_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign w_in_ready = !r_s1_valid || w_s2_free;
  assign w_in_xfer  = bus.in_valid && w_in_ready;

  // Subtraction as a + ~b + 1; bit HALF of the low sum is the carry (1 = no borrow).
  assign w_lo = {1'b0, bus.n1[HALF-1:0]} + {1'b0, ~bus.n2[HALF-1:0]} + {{HALF{1'b0}}, 1'b1};
  assign w_hi = {r_n1_hi[HALF-1], r_n1_hi} + ~{r_n2_hi[HALF-1], r_n2_hi}
              + {{HALF{1'b0}}, r_s1_lo[HALF]};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the same-edge advance/load/drain ordering is race-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_n1_hi    <= '0;
      r_n2_hi    <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_lo    <= w_lo;
      r_n1_hi    <= bus.n1[WIDTH-1:HALF];
      r_n2_hi    <= bus.n2[WIDTH-1:HALF];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_ovf       <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_diff      <= {w_hi, r_s1_lo[HALF-1:0]};
      r_ovf       <= w_hi[HALF] ^ w_hi[HALF-1];
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed bench for pipelined_subtractor: vector table, streaming with backpressure, async reset mid-flight.
module tb_pipelined_subtractor;

  typedef struct {
    logic [15:0] n1;
    logic [15:0] n2;
    logic [16:0] exp_diff;
    logic        exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [12];

  pipelined_subtractor_if #(.WIDTH(16)) bus ();

  pipelined_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   sent;
    int   got;
    int   last_out_cyc;
    bit   saw_block;
    bit   prev_stall;
    logic [16:0] prev_diff;
    logic in_x;
    logic out_x;

    vecs[0]  = '{16'h0005, 16'h0003, 17'h00002, 1'b0};
    vecs[1]  = '{16'h0100, 16'h0001, 17'h000FF, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 17'h1FFFF, 1'b0};
    vecs[3]  = '{16'hFF80, 16'h0080, 17'h1FF00, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 17'h17FFF, 1'b1};
    vecs[5]  = '{16'h7FFF, 16'hFFFF, 17'h08000, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 17'h00000, 1'b0};
    vecs[7]  = '{16'h1234, 16'h0234, 17'h01000, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h8000, 17'h0FFFF, 1'b1};
    vecs[9]  = '{16'h8000, 16'h7FFF, 17'h10001, 1'b1};
    vecs[10] = '{16'h00FF, 16'hFF01, 17'h001FE, 1'b0};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 17'h00000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.n1        = '0;
    bus.n2        = '0;
    bus.out_ready = 1'b1;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single isolated ops: result valid for exactly one cycle, one edge after the transfer edge.
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.n1 = vecs[i].n1;
      bus.n2 = vecs[i].n2;
      step();
      bus.in_valid = 1'b0;
      bus.n1 = 16'hDEAD;
      bus.n2 = 16'hBEEF;
      check($sformatf("v%0d_lat_early", i), 32'(bus.out_valid), 32'd0);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_diff", i), 32'(bus.diff), 32'(vecs[i].exp_diff));
      check($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
      step();
      check($sformatf("v%0d_one_cycle", i), 32'(bus.out_valid), 32'd0);
    end

    // Six back-to-back ops with out_ready dropped for cycles 3..5.
    sent = 0;
    got = 0;
    last_out_cyc = -1;
    saw_block = 1'b0;
    prev_stall = 1'b0;
    prev_diff = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      bus.in_valid  = (sent < 6);
      bus.n1 = (sent < 6) ? vecs[sent].n1 : 16'h0;
      bus.n2 = (sent < 6) ? vecs[sent].n2 : 16'h0;
      #1;
      if (prev_stall) check("stall_diff_hold", 32'(bus.diff), 32'(prev_diff));
      if (bus.out_ready) check("in_ready_when_drained", 32'(bus.in_ready), 32'd1);
      else if (!bus.in_ready) saw_block = 1'b1;
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      if (out_x) begin
        check($sformatf("stream%0d_diff", got), 32'(bus.diff), 32'(vecs[got].exp_diff));
        check($sformatf("stream%0d_ovf", got), 32'(bus.ovf), 32'(vecs[got].exp_ovf));
        got++;
        last_out_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_diff  = bus.diff;
      if (in_x) sent++;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd6);
    check("stream_in_ready_fell", 32'(saw_block), 32'd1);
    check("stream_last_cycle", 32'(last_out_cyc), 32'd10);
    step();
    check("stream_drained", 32'(bus.out_valid), 32'd0);

    // Fill both stages under stall, then assert reset between edges.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.n1 = vecs[4 + i].n1;
      bus.n2 = vecs[4 + i].n2;
      step();
    end
    bus.in_valid = 1'b0;
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_diff", 32'(bus.diff), 32'd0);
    check("async_ovf", 32'(bus.ovf), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stale_result", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
